cache_refill_arbiter: RTL and testbench
=======================================

Name: cache_refill_arbiter

Overview:
Shares one memory refill port between the instruction cache (I-side) and the data cache (D-side) miss paths. It accepts line-refill requests from both caches, grants them round-robin, and issues one request at a time on the memory port with a req/ack handshake and a timeout. It returns the refill word to the winning cache as a one-cycle ready pulse, matching the cache's iready-style refill input. It also keeps saturating grant counters for performance reporting.

Parameters:
ADDR_W, 32, address width of requests and memory port
DATA_W, 32, refill data width
LINE_BYTES, 4, cache line size in bytes (power of 2); request addresses are aligned down to it
TIMEOUT, 255, max cycles mem_req may wait for mem_ack (>=2)
CNT_W, 16, width of grant counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  I-cache miss request, level, held until i_rsp_ready seen
i_addr  input  ADDR_W  I-cache miss address (fetchaddr)
i_rsp_ready  output  1  one-cycle pulse: i_rsp_data valid for I-cache refill
i_rsp_data  output  DATA_W  refill word to I-cache
d_req  input  1  D-cache miss request, same rules as i_req
d_addr  input  ADDR_W  D-cache miss address
d_rsp_ready  output  1  one-cycle pulse: d_rsp_data valid
d_rsp_data  output  DATA_W  refill word to D-cache
rsp_err  output  1  valid with either rsp_ready pulse; 1 = timed out, data is 0
mem_req  output  1  memory request, held until mem_ack
mem_addr  output  ADDR_W  line-aligned address, stable while mem_req=1
mem_ack  input  1  memory accepted/returned; mem_rdata valid this cycle
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in any state other than IDLE
i_grants  output  CNT_W  saturating count of I-side grants
d_grants  output  CNT_W  saturating count of D-side grants

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_req, mem_addr, i/d_rsp_ready, i/d_rsp_data, rsp_err, busy, and both counters. last_grant=D, so I wins the first tie. Reset mid-transaction aborts immediately; a mem_ack that arrives after reset is ignored.
- States: IDLE, WAIT, RESPOND, GAP.
- IDLE:
  - Sample eligible requests at the clock edge.
  - If only one is eligible, grant it.
  - If both are eligible, grant the side that is not last_grant.
  - On grant, latch owner and latch mem_addr = addr with its low log2(LINE_BYTES) bits cleared.
  - Set mem_req=1 and move to WAIT. mem_req is first visible the cycle after the request is sampled.
  - Update last_grant and increment that side's counter; the counter holds at all-ones and does not wrap.
- WAIT:
  - mem_req and mem_addr are held constant. A wait counter counts cycles with mem_ack=0.
  - On mem_ack=1: capture mem_rdata, set mem_req=0 next cycle, rsp_err=0, go to RESPOND.
  - If the counter reaches TIMEOUT with mem_ack still 0: set mem_req=0, captured data=0, rsp_err=1, go to RESPOND.
  - If mem_ack and the timeout coincide, the ack wins (no error).
  - Requests from the other side arriving during WAIT stay pending.
  - An owner deasserting its req during WAIT does not cancel the transaction.
- RESPOND:
  - Exactly one cycle.
  - The owner's rsp_ready=1, its rsp_data = captured data, and rsp_err as set in WAIT.
  - The non-owner's rsp_ready stays 0.
  - Next state is GAP.
- GAP:
  - One cycle; rsp_ready=0.
  - The served side's req is ignored this cycle so the cache can deassert it.
  - If the other side is requesting, grant it directly from GAP using the same actions as the IDLE grant. Otherwise go to IDLE.
- Response data: rsp_data holds its last value between pulses; caches must qualify it with rsp_ready.
- Response latency: miss to refill = 1 (issue) + memory wait + 1 (RESPOND) cycles. With mem_ack in the first mem_req cycle, rsp_ready pulses 2 cycles after req is sampled.
- Back-to-back: continuous requests from both sides alternate I, D, I, D with 2 idle cycles on mem_req between transactions. No requester is starved.
- Requester obligations: keep req and addr stable until rsp_ready, and deassert req in the cycle after rsp_ready. A req still high in the IDLE cycle after GAP is treated as a new miss.

Test Plan:
- Reset, then i_req=1 with i_addr=0x0000000B; mem_ack on the first mem_req cycle with mem_rdata=0x10000003 -> mem_addr=0x00000008; i_rsp_ready pulses one cycle with i_rsp_data=0x10000003, rsp_err=0; i_grants=1; d_rsp_ready stays 0.
- i_req and d_req raised in the same cycle (addrs 0x0C, 0x40) with mem_ack after 3 cycles each -> I is served first (mem_addr=0x0C), then D (0x40); i_grants=1, d_grants=1.
- Both sides requesting for 6 transactions -> grant order I, D, I, D, I, D; mem_req low exactly 2 cycles between transactions.
- D-side request with mem_ack never asserted, TIMEOUT=8 -> mem_req drops after 8 wait cycles; d_rsp_ready pulses with d_rsp_data=0, rsp_err=1; the next request is serviced normally.
- mem_ack asserted in exactly the timeout cycle -> data is returned, rsp_err=0.
- Reset asserted during WAIT, then mem_ack pulsed -> all outputs 0 the cycle after reset; no rsp_ready pulse; counters=0. Counter saturation with CNT_W=2 and 5 I grants -> i_grants holds at 3.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: shares one memory refill port between the I-cache and
// D-cache miss paths. Requests are granted round-robin, one transaction is in
// flight at a time, and the refill word goes back to the winning cache as a
// one-cycle ready pulse. A transaction that is never acked times out and
// returns zero data with rsp_err set. Grant counters saturate at all-ones.
module cache_refill_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rsp_ready,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              rsp_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  // Wait counter only needs to reach TIMEOUT-1: the TIMEOUT-th unacked
  // cycle is the one that gives up.
  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1'b1);
  localparam logic [WCNT_W-1:0] WAIT_ZERO = {WCNT_W{1'b0}};

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

  // Clear the byte-offset bits so memory always sees the line base.
  function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_t              state_r, state_s;
  logic                owner_r, owner_s;
  logic                last_grant_r, last_grant_s;
  logic [WCNT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic                mem_req_r, mem_req_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic                i_rdy_r, i_rdy_s;
  logic                d_rdy_r, d_rdy_s;
  logic [DATA_W-1:0]   i_data_r, i_data_s;
  logic [DATA_W-1:0]   d_data_r, d_data_s;
  logic                err_r, err_s;
  logic                busy_r, busy_s;
  logic [CNT_W-1:0]    i_cnt_r, i_cnt_s;
  logic [CNT_W-1:0]    d_cnt_r, d_cnt_s;

  logic                elig_i_s, elig_d_s;
  logic                grant_any_s;
  logic                grant_side_s;
  logic [ADDR_W-1:0]   grant_addr_s;

  // Round-robin pick; in GAP the side just served is masked out.
  always_comb begin
    elig_i_s     = i_req && !((state_r == ST_GAP) && (owner_r == SIDE_I));
    elig_d_s     = d_req && !((state_r == ST_GAP) && (owner_r == SIDE_D));
    grant_any_s  = elig_i_s || elig_d_s;
    grant_side_s = SIDE_I;
    if (elig_i_s && elig_d_s) begin
      grant_side_s = ~last_grant_r;
    end else if (elig_d_s) begin
      grant_side_s = SIDE_D;
    end else begin
      grant_side_s = SIDE_I;
    end
    grant_addr_s = align_line((grant_side_s == SIDE_D) ? d_addr : i_addr);
  end

  // Next-state and next-output logic of the refill FSM.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    wait_cnt_s   = wait_cnt_r;
    mem_req_s    = mem_req_r;
    mem_addr_s   = mem_addr_r;
    i_rdy_s      = 1'b0;
    d_rdy_s      = 1'b0;
    i_data_s     = i_data_r;
    d_data_s     = d_data_r;
    err_s        = err_r;
    i_cnt_s      = i_cnt_r;
    d_cnt_s      = d_cnt_r;

    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (grant_any_s) begin
          state_s      = ST_WAIT;
          owner_s      = grant_side_s;
          last_grant_s = grant_side_s;
          wait_cnt_s   = WAIT_ZERO;
          mem_req_s    = 1'b1;
          mem_addr_s   = grant_addr_s;
          if (grant_side_s == SIDE_D) begin
            d_cnt_s = sat_inc(d_cnt_r);
          end else begin
            i_cnt_s = sat_inc(i_cnt_r);
          end
        end else begin
          state_s   = ST_IDLE;
          mem_req_s = 1'b0;
        end
      end
      ST_WAIT: begin
        // An ack in the timeout cycle still delivers data.
        if (mem_ack || (wait_cnt_r == WAIT_LAST)) begin
          state_s   = ST_RESPOND;
          mem_req_s = 1'b0;
          err_s     = !mem_ack;
          if (owner_r == SIDE_D) begin
            d_rdy_s  = 1'b1;
            d_data_s = mem_ack ? mem_rdata : {DATA_W{1'b0}};
          end else begin
            i_rdy_s  = 1'b1;
            i_data_s = mem_ack ? mem_rdata : {DATA_W{1'b0}};
          end
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      ST_RESPOND: begin
        state_s = ST_GAP;
      end
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transaction bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r      <= SIDE_I;
      last_grant_r <= SIDE_D;
      wait_cnt_r   <= WAIT_ZERO;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      i_rdy_r      <= 1'b0;
      d_rdy_r      <= 1'b0;
      i_data_r     <= {DATA_W{1'b0}};
      d_data_r     <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      i_cnt_r      <= {CNT_W{1'b0}};
      d_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      wait_cnt_r   <= wait_cnt_s;
      mem_req_r    <= mem_req_s;
      mem_addr_r   <= mem_addr_s;
      i_rdy_r      <= i_rdy_s;
      d_rdy_r      <= d_rdy_s;
      i_data_r     <= i_data_s;
      d_data_r     <= d_data_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
      i_cnt_r      <= i_cnt_s;
      d_cnt_r      <= d_cnt_s;
    end
  end

  assign i_rsp_ready = i_rdy_r;
  assign i_rsp_data  = i_data_r;
  assign d_rsp_ready = d_rdy_r;
  assign d_rsp_data  = d_data_r;
  assign rsp_err     = err_r;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign busy        = busy_r;
  assign i_grants    = i_cnt_r;
  assign d_grants    = d_cnt_r;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: directed requester/memory stimulus, a
// transaction-level reference model compared every cycle, plus literal
// expectations for the hand-computed scenarios.
module tb_cache_refill_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LB = 4;
  localparam int TO = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          i_rsp_ready, d_rsp_ready, rsp_err, mem_req, busy;
  logic [DW-1:0] i_rsp_data, d_rsp_data;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] i_grants, d_grants;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit force_ack = 1'b0;

  cache_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .d_req(d_req), .d_addr(d_addr), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .rsp_err(rsp_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .i_grants(i_grants), .d_grants(d_grants)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic        exp_mem_req, exp_i_rdy, exp_d_rdy, exp_err, exp_busy;
  logic [31:0] exp_mem_addr, exp_i_data, exp_d_data;
  int          m_ig, m_dg;
  bit          m_last, m_abort;

  function automatic void m_zero();
    exp_mem_req = 1'b0; exp_mem_addr = 32'd0; exp_i_rdy = 1'b0; exp_d_rdy = 1'b0;
    exp_i_data = 32'd0; exp_d_data = 32'd0; exp_err = 1'b0; exp_busy = 1'b0;
    m_ig = 0; m_dg = 0; m_last = 1'b1;
  endfunction

  task automatic m_edge();
    @(posedge clk);
    if (reset === 1'b1) begin
      m_zero();
      m_abort = 1'b1;
    end
  endtask

  function automatic void m_grant(input bit side);
    exp_mem_req  = 1'b1;
    exp_busy     = 1'b1;
    exp_mem_addr = (side ? d_addr : i_addr) & ~32'(LB - 1);
    m_last       = side;
    if (side) m_dg = (m_dg < CNT_MAX) ? m_dg + 1 : m_dg;
    else      m_ig = (m_ig < CNT_MAX) ? m_ig + 1 : m_ig;
  endfunction

  // One or more chained transactions starting with a grant to 'first'.
  task automatic m_run(input bit first);
    bit side;
    int waited;
    logic [31:0] data;
    bit err;
    side = first;
    forever begin
      m_grant(side);
      waited = 0;
      forever begin
        m_edge();
        if (m_abort) return;
        if (mem_ack === 1'b1) begin data = mem_rdata; err = 1'b0; break; end
        waited++;
        if (waited == TO) begin data = 32'd0; err = 1'b1; break; end
      end
      exp_mem_req = 1'b0;
      exp_err = err;
      if (side) begin exp_d_rdy = 1'b1; exp_d_data = data; end
      else      begin exp_i_rdy = 1'b1; exp_i_data = data; end
      m_edge();
      if (m_abort) return;
      exp_i_rdy = 1'b0;
      exp_d_rdy = 1'b0;
      m_edge();
      if (m_abort) return;
      if ((side ? i_req : d_req) === 1'b1) begin
        side = !side;
      end else begin
        exp_busy = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    m_zero();
    forever begin
      m_abort = 1'b0;
      m_edge();
      if (!m_abort) begin
        if (i_req === 1'b1 && d_req === 1'b1) m_run(!m_last);
        else if (i_req === 1'b1)              m_run(1'b0);
        else if (d_req === 1'b1)              m_run(1'b1);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("mem_req", 32'(mem_req), 32'(exp_mem_req));
        if (exp_mem_req) cmp("mem_addr", mem_addr, exp_mem_addr);
        cmp("busy", 32'(busy), 32'(exp_busy));
        cmp("i_rsp_ready", 32'(i_rsp_ready), 32'(exp_i_rdy));
        cmp("d_rsp_ready", 32'(d_rsp_ready), 32'(exp_d_rdy));
        cmp("i_rsp_data", i_rsp_data, exp_i_data);
        cmp("d_rsp_data", d_rsp_data, exp_d_data);
        if (exp_i_rdy || exp_d_rdy) cmp("rsp_err", 32'(rsp_err), 32'(exp_err));
        cmp("i_grants", 32'(i_grants), 32'(m_ig));
        cmp("d_grants", 32'(d_grants), 32'(m_dg));
      end
    end
  end

  // ---------------- memory responder ----------------
  int          ack_q[$];
  logic [31:0] dat_q[$];
  bit          inflight = 1'b0;
  int          cnt, cur_dly;
  logic [31:0] cur_dat;

  initial begin
    forever begin
      @(negedge clk);
      mem_ack = force_ack;
      if (mem_req !== 1'b1) begin
        inflight = 1'b0;
      end else begin
        if (!inflight) begin
          inflight = 1'b1;
          cnt = 0;
          if (ack_q.size() > 0) begin cur_dly = ack_q.pop_front(); cur_dat = dat_q.pop_front(); end
          else cur_dly = -1;
        end
        if (cur_dly >= 0 && cnt == cur_dly) begin mem_ack = 1'b1; mem_rdata = cur_dat; end
        cnt++;
      end
    end
  end

  // ---------------- mem_req monitor ----------------
  logic [31:0] addr_log[$];
  int gap_log[$], hi_log[$];
  bit mon_prev = 1'b0, mon_seen = 1'b0;
  int low_len = 0, hi_len = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!mon_prev) begin
          addr_log.push_back(mem_addr);
          if (mon_seen) gap_log.push_back(low_len);
          mon_seen = 1'b1;
          hi_len = 0;
        end
        hi_len++;
        mon_prev = 1'b1;
      end else begin
        if (mon_prev) begin hi_log.push_back(hi_len); low_len = 1; end
        else low_len++;
        mon_prev = 1'b0;
      end
    end
  end

  // ---------------- requesters ----------------
  bit          order_q[$];
  logic [31:0] data_q[$];
  bit          err_q[$];

  task automatic clear_logs();
    order_q.delete(); data_q.delete(); err_q.delete();
    addr_log.delete(); gap_log.delete(); hi_log.delete();
    mon_seen = 1'b0;
  endtask

  task automatic requester(input bit side, input int n, input logic [31:0] base);
    int w;
    bit got;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (side) begin d_req = 1'b1; d_addr = base + 32'(4 * k); end
      else      begin i_req = 1'b1; i_addr = base + 32'(4 * k); end
      w = 0;
      got = 1'b0;
      while (!got && w < 100) begin
        @(negedge clk);
        w++;
        if ((side ? d_rsp_ready : i_rsp_ready) === 1'b1) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL %s_wait: no response within %0d cycles", side ? "d" : "i", w);
      end else begin
        order_q.push_back(side);
        data_q.push_back(side ? d_rsp_data : i_rsp_data);
        err_q.push_back(rsp_err);
      end
      @(negedge clk);
      if (side) d_req = 1'b0; else i_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    cmp("rst_mem_req", 32'(mem_req), 32'd0);
    cmp("rst_mem_addr", mem_addr, 32'd0);
    cmp("rst_i_rdy", 32'(i_rsp_ready), 32'd0);
    cmp("rst_d_rdy", 32'(d_rsp_ready), 32'd0);
    cmp("rst_i_data", i_rsp_data, 32'd0);
    cmp("rst_d_data", d_rsp_data, 32'd0);
    cmp("rst_err", 32'(rsp_err), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_i_grants", 32'(i_grants), 32'd0);
    cmp("rst_d_grants", 32'(d_grants), 32'd0);
    clear_logs();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] ea;

    // 1: single I miss, ack on first mem_req cycle
    do_reset();
    ack_q.push_back(0); dat_q.push_back(32'h1000_0003);
    @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_000B;
    @(negedge clk);
    cmp("t1_mem_req", 32'(mem_req), 32'd1);
    cmp("t1_mem_addr", mem_addr, 32'h0000_0008);
    @(negedge clk);
    cmp("t1_i_rdy", 32'(i_rsp_ready), 32'd1);
    cmp("t1_i_data", i_rsp_data, 32'h1000_0003);
    cmp("t1_err", 32'(rsp_err), 32'd0);
    cmp("t1_d_rdy", 32'(d_rsp_ready), 32'd0);
    @(negedge clk); i_req = 1'b0;
    cmp("t1_i_rdy_low", 32'(i_rsp_ready), 32'd0);
    idle_cycles(2);
    cmp("t1_i_grants", 32'(i_grants), 32'd1);
    cmp("t1_d_grants", 32'(d_grants), 32'd0);
    cmp("t1_busy", 32'(busy), 32'd0);

    // 2: simultaneous requests, I wins first tie
    do_reset();
    ack_q.push_back(3); dat_q.push_back(32'hAAAA_0001);
    ack_q.push_back(3); dat_q.push_back(32'hBBBB_0002);
    fork
      requester(1'b0, 1, 32'h0000_000C);
      requester(1'b1, 1, 32'h0000_0040);
    join
    idle_cycles(3);
    cmp("t2_n", order_q.size(), 32'd2);
    cmp("t2_first", 32'(order_q[0]), 32'd0);
    cmp("t2_second", 32'(order_q[1]), 32'd1);
    cmp("t2_addr0", addr_log[0], 32'h0000_000C);
    cmp("t2_addr1", addr_log[1], 32'h0000_0040);
    cmp("t2_data_i", data_q[0], 32'hAAAA_0001);
    cmp("t2_data_d", data_q[1], 32'hBBBB_0002);
    cmp("t2_i_grants", 32'(i_grants), 32'd1);
    cmp("t2_d_grants", 32'(d_grants), 32'd1);

    // 3: continuous requests from both sides alternate with 2-cycle gaps
    do_reset();
    for (int k = 0; k < 6; k++) begin ack_q.push_back(1); dat_q.push_back(32'h3000_0000 + 32'(k)); end
    fork
      requester(1'b0, 3, 32'h0000_0100);
      requester(1'b1, 3, 32'h0000_0200);
    join
    idle_cycles(3);
    cmp("t3_n", order_q.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      cmp("t3_order", 32'(order_q[k]), 32'(k % 2));
      ea = ((k % 2) ? 32'h200 : 32'h100) + 32'(4 * (k / 2));
      cmp("t3_addr", addr_log[k], ea);
    end
    cmp("t3_ngaps", gap_log.size(), 32'd5);
    for (int k = 0; k < 5; k++) cmp("t3_gap", 32'(gap_log[k]), 32'd2);
    cmp("t3_i_grants", 32'(i_grants), 32'd3);
    cmp("t3_d_grants", 32'(d_grants), 32'd3);

    // 4: D timeout, then a normal D request
    do_reset();
    ack_q.push_back(-1); dat_q.push_back(32'hDEAD_BEEF);
    ack_q.push_back(0);  dat_q.push_back(32'hCAFE_0001);
    requester(1'b1, 2, 32'h0000_0080);
    idle_cycles(3);
    cmp("t4_hi0", 32'(hi_log[0]), 32'd8);
    cmp("t4_data0", data_q[0], 32'd0);
    cmp("t4_err0", 32'(err_q[0]), 32'd1);
    cmp("t4_hi1", 32'(hi_log[1]), 32'd1);
    cmp("t4_data1", data_q[1], 32'hCAFE_0001);
    cmp("t4_err1", 32'(err_q[1]), 32'd0);

    // 5: ack in exactly the timeout cycle wins
    do_reset();
    ack_q.push_back(TO - 1); dat_q.push_back(32'h5A5A_0005);
    requester(1'b0, 1, 32'h0000_0010);
    idle_cycles(3);
    cmp("t5_hi", 32'(hi_log[0]), 32'd8);
    cmp("t5_data", data_q[0], 32'h5A5A_0005);
    cmp("t5_err", 32'(err_q[0]), 32'd0);

    // 6: reset during WAIT, late ack ignored
    do_reset();
    ack_q.push_back(-1); dat_q.push_back(32'h0);
    @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0030;
    idle_cycles(3);
    cmp("t6_in_wait", 32'(mem_req), 32'd1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cmp("t6_mem_req", 32'(mem_req), 32'd0);
    cmp("t6_mem_addr", mem_addr, 32'd0);
    cmp("t6_busy", 32'(busy), 32'd0);
    cmp("t6_i_grants", 32'(i_grants), 32'd0);
    force_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk); force_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmp("t6_no_rdy", 32'(i_rsp_ready), 32'd0);
      cmp("t6_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end

    // 7: grant counter saturation at CNT_W=2
    do_reset();
    for (int k = 0; k < 5; k++) begin ack_q.push_back(0); dat_q.push_back(32'h7000_0000 + 32'(k)); end
    requester(1'b0, 5, 32'h0000_0300);
    idle_cycles(3);
    cmp("t7_i_grants", 32'(i_grants), 32'd3);
    cmp("t7_d_grants", 32'(d_grants), 32'd0);
    cmp("t7_last_data", data_q[4], 32'h7000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
